// File: rtl/trace_injector_if.sv
// Host load port, replay commands and NetFPGA-style output datapath of the trace injector.
interface trace_injector_if #(
   parameter int AW     = 9,
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
);
   logic              host_wr;
   logic [1:0]        host_sel;
   logic [31:0]       host_wdata;
   logic              cmd_start;
   logic              cmd_stop;
   logic              cmd_loop;
   logic [AW:0]       num_entries;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              out_wr;
   logic              out_rdy;
   logic              busy;
   logic              done;
   logic [15:0]       replay_count;
   logic              write_err;

   modport master (
      output host_wr, host_sel, host_wdata, cmd_start, cmd_stop, cmd_loop, num_entries, out_rdy,
      input  out_data, out_ctrl, out_wr, busy, done, replay_count, write_err
   );
   modport slave (
      input  host_wr, host_sel, host_wdata, cmd_start, cmd_stop, cmd_loop, num_entries, out_rdy,
      output out_data, out_ctrl, out_wr, busy, done, replay_count, write_err
   );
endinterface

// File: rtl/trace_injector.sv
// Replays a host-loaded trace RAM onto a pipeline datapath, single-shot or looped,
// stopping only at packet boundaries (ctrl == all ones marks a header).
module trace_injector #(
   parameter int DEPTH  = 512,
   parameter int AW     = 9,
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   trace_injector_if.slave bus
);
   localparam int EW = CTRL_W + DATA_W;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   logic [EW-1:0]     r_mem [DEPTH];
   logic [EW-1:0]     r_q;
   logic              r_q_vld, r_q_last;
   logic [EW:0]       r_fifo [2];
   logic              r_wp, r_rp;
   logic [1:0]        r_cnt;
   logic [AW-1:0]     r_ptr;
   logic [AW:0]       r_n;
   logic              r_loop, r_stop, r_end, r_issue_done;
   logic [DATA_W-1:0] r_stg_data;
   logic [CTRL_W-1:0] r_stg_ctrl;
   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic              r_out_wr, r_busy, r_done, r_write_err;
   logic [15:0]       r_replay;

   logic [AW:0]   w_clamp;
   logic          w_start, w_commit, w_commit_ok;
   logic          w_avail, w_hdr_stop, w_run, w_pop, w_fpop, w_push, w_issue, w_last_ptr;
   logic [EW:0]   w_head;
   logic [2:0]    w_occ;

   assign w_clamp     = (bus.num_entries > DEPTH_C) ? DEPTH_C : bus.num_entries;
   assign w_start     = bus.cmd_start && !r_busy && (w_clamp != '0);
   assign w_commit    = bus.host_wr && (bus.host_sel == 2'd3);
   // busy is already considered set on the edge that accepts a start
   assign w_commit_ok = w_commit && !r_busy && !w_start;

   // Head of the output queue: staged words first, then the RAM read stage
   assign w_avail    = (r_cnt != 2'd0) || r_q_vld;
   assign w_head     = (r_cnt != 2'd0) ? r_fifo[r_rp] : {r_q_last, r_q};
   assign w_hdr_stop = r_stop && w_avail && (w_head[EW-1 -: CTRL_W] == {CTRL_W{1'b1}});
   assign w_run      = (r_state == S_RUN) && !r_end && !w_hdr_stop;
   assign w_pop      = w_run && bus.out_rdy && w_avail;
   assign w_fpop     = w_pop && (r_cnt != 2'd0);
   assign w_push     = r_q_vld && !(w_pop && (r_cnt == 2'd0));
   // Issue only if the word it returns can still be parked should out_rdy drop
   assign w_occ      = 3'(r_cnt) + 3'(r_q_vld) - 3'(w_pop);
   assign w_issue    = w_run && !r_issue_done && (w_occ < 3'd2);
   assign w_last_ptr = ({1'b0, r_ptr} == (r_n - (AW+1)'(1)));

   always_ff @(posedge clk) begin
      if (w_commit_ok) r_mem[bus.host_wdata[AW-1:0]] <= {r_stg_ctrl, r_stg_data};
      if (w_issue)     r_q <= r_mem[r_ptr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_q_vld      <= 1'b0;
         r_q_last     <= 1'b0;
         r_fifo[0]    <= '0;
         r_fifo[1]    <= '0;
         r_wp         <= 1'b0;
         r_rp         <= 1'b0;
         r_cnt        <= 2'd0;
         r_ptr        <= '0;
         r_n          <= '0;
         r_loop       <= 1'b0;
         r_stop       <= 1'b0;
         r_end        <= 1'b0;
         r_issue_done <= 1'b0;
         r_stg_data   <= '0;
         r_stg_ctrl   <= '0;
         r_out_data   <= '0;
         r_out_ctrl   <= '0;
         r_out_wr     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_replay     <= '0;
         r_write_err  <= 1'b0;
      end else begin
         if (bus.host_wr && bus.host_sel == 2'd0) r_stg_data[31:0]  <= bus.host_wdata;
         if (bus.host_wr && bus.host_sel == 2'd1) r_stg_data[63:32] <= bus.host_wdata;
         if (bus.host_wr && bus.host_sel == 2'd2) r_stg_ctrl        <= bus.host_wdata[CTRL_W-1:0];
         if (w_start)                   r_write_err <= 1'b0;
         if (w_commit && !w_commit_ok)  r_write_err <= 1'b1;

         r_q_vld <= w_issue;
         if (w_issue) begin
            r_q_last <= w_last_ptr;
            r_ptr    <= w_last_ptr ? '0 : r_ptr + 1'b1;
            if (w_last_ptr && !r_loop) r_issue_done <= 1'b1;
         end
         if (w_push) begin
            r_fifo[r_wp] <= {r_q_last, r_q};
            r_wp         <= ~r_wp;
         end
         if (w_fpop) r_rp <= ~r_rp;
         r_cnt    <= r_cnt + 2'(w_push) - 2'(w_fpop);
         r_out_wr <= 1'b0;

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_state      <= S_RUN;
                  r_ptr        <= '0;
                  r_n          <= w_clamp;
                  r_loop       <= bus.cmd_loop;
                  r_stop       <= 1'b0;
                  r_end        <= 1'b0;
                  r_issue_done <= 1'b0;
                  r_replay     <= '0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.cmd_stop) r_stop <= 1'b1;
               if (r_end || w_hdr_stop) begin
                  r_state <= S_DRAIN;
               end else if (w_pop) begin
                  r_out_wr   <= 1'b1;
                  r_out_ctrl <= w_head[EW-1 -: CTRL_W];
                  r_out_data <= w_head[DATA_W-1:0];
                  if (w_head[EW]) begin
                     if (r_replay != 16'hFFFF) r_replay <= r_replay + 16'd1;
                     if (!r_loop || r_stop) r_end <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // In-flight read has retired; drop anything prefetched
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_cnt   <= 2'd0;
               r_wp    <= 1'b0;
               r_rp    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.out_data     = r_out_data;
   assign bus.out_ctrl     = r_out_ctrl;
   assign bus.out_wr       = r_out_wr;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.replay_count = r_replay;
   assign bus.write_err    = r_write_err;
endmodule
